// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel runtime-programmable 50% duty clock divider
// Optional feature macro: PROG_CLKDIV_SYNC_EN (adds sync_restart for phase alignment of all running channels).
module prog_clock_divider #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 27,
    parameter int DEFAULT_FREQ = 3,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  ch_en,
    input  logic                 load,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic [CNT_WIDTH-1:0] half_period,
`ifdef PROG_CLKDIV_SYNC_EN
    input  logic                 sync_restart,
`endif
    output logic                 load_ack,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  tick
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam longint DEF_HP_RAW = longint'(CLK_FREQ) / (2 * longint'(DEFAULT_FREQ));
    localparam logic [CNT_WIDTH-1:0] DEF_HP_TRUNC = CNT_WIDTH'(DEF_HP_RAW);
    // A zero half-period would never reach terminal count; treat it like a load of 0.
    localparam logic [CNT_WIDTH-1:0] DEF_HP = (DEF_HP_TRUNC == '0) ? CNT_WIDTH'(1) : DEF_HP_TRUNC;

    state_t               state_q   [CHANNELS];
    state_t               state_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q     [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d     [CHANNELS];
    logic [CNT_WIDTH-1:0] hp_act_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] hp_act_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] hp_pend_q [CHANNELS];
    logic [CNT_WIDTH-1:0] hp_pend_d [CHANNELS];
    logic [CHANNELS-1:0]  pend_q, pend_d;
    logic [CHANNELS-1:0]  clk_out_q, clk_out_d;
    logic [CHANNELS-1:0]  tick_q, tick_d;
    logic                 load_ack_q, load_ack_d;

    logic                 load_ok;
    logic [CNT_WIDTH-1:0] load_val;

    // Accept only in-range targets; a zero half-period is clamped to 1 (clk_in/2).
    always_comb begin
        load_ok  = load && (32'(ch_sel) < 32'(CHANNELS));
        load_val = (half_period == '0) ? CNT_WIDTH'(1) : half_period;
    end

    // Per-channel next state: counting, toggling, drain-to-low on disable, reload application.
    always_comb begin
        load_ack_d = load_ok;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            hp_act_d[i]  = hp_act_q[i];
            hp_pend_d[i] = hp_pend_q[i];
            pend_d[i]    = pend_q[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            if (state_q[i] == ST_OFF) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
                if (ch_en[i]) begin
                    state_d[i] = ST_RUN;
                end
            end else if (!ch_en[i] && !clk_out_q[i]) begin
                // Disabled while low: stop at once, nothing is truncated.
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
                if (pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
            end else if (cnt_q[i] == hp_act_q[i] - CNT_WIDTH'(1)) begin
                // Terminal count: toggle, and swap in any pending half-period for the next phase.
                cnt_d[i]     = '0;
                clk_out_d[i] = ~clk_out_q[i];
                tick_d[i]    = ~clk_out_q[i];
                if (pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
                // A disabled channel only reaches here while high, so this edge is its final fall.
                state_d[i] = ch_en[i] ? ST_RUN : ST_OFF;
            end else begin
                cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
                state_d[i] = ch_en[i] ? ST_RUN : ST_DRAIN;
            end

`ifdef PROG_CLKDIV_SYNC_EN
            // Restart wins over a coincident terminal count; all active channels restart low.
            if (sync_restart && (state_q[i] != ST_OFF)) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                if (pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
                state_d[i] = ch_en[i] ? ST_RUN : ST_OFF;
            end
`endif

            // Stopped channels take a new value immediately; running ones wait for terminal count.
            if (load_ok && (ch_sel == SEL_W'(i))) begin
                if (state_q[i] == ST_OFF) begin
                    hp_act_d[i] = load_val;
                    pend_d[i]   = 1'b0;
                end else begin
                    hp_pend_d[i] = load_val;
                    pend_d[i]    = 1'b1;
                end
            end
        end
    end

    // State registers; reset restores the default half-period and drops pending loads.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= ST_OFF;
                cnt_q[i]     <= '0;
                hp_act_q[i]  <= DEF_HP;
                hp_pend_q[i] <= DEF_HP;
            end
            pend_q     <= '0;
            clk_out_q  <= '0;
            tick_q     <= '0;
            load_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hp_act_q   <= hp_act_d;
            hp_pend_q  <= hp_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            load_ack_q <= load_ack_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign load_ack = load_ack_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - randomized self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

    localparam int CH     = 3;
    localparam int CW     = 8;
    localparam int CF     = 100;
    localparam int DF     = 10;
    localparam int DEF_HP = CF / (2 * DF);

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic [CH-1:0] ch_en  = '0;
    logic          load   = 1'b0;
    logic [1:0]    ch_sel = '0;
    logic [CW-1:0] half_period = '0;
`ifdef PROG_CLKDIV_SYNC_EN
    logic          sync_restart = 1'b0;
`endif
    logic          load_ack;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a level plus the number of cycles left in the current phase.
    bit m_run  [CH];
    bit m_lvl  [CH];
    bit m_tick [CH];
    bit m_pend [CH];
    int m_rem  [CH];
    int m_hp   [CH];
    int m_hpp  [CH];
    bit m_ack;

    logic [CH-1:0] en_v = '0;

    prog_clock_divider #(
        .CLK_FREQ    (CF),
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .DEFAULT_FREQ(DF)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .ch_en       (ch_en),
        .load        (load),
        .ch_sel      (ch_sel),
        .half_period (half_period),
`ifdef PROG_CLKDIV_SYNC_EN
        .sync_restart(sync_restart),
`endif
        .load_ack    (load_ack),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_lvl[c]  = 0;
            m_tick[c] = 0;
            m_pend[c] = 0;
            m_rem[c]  = 0;
            m_hp[c]   = DEF_HP;
            m_hpp[c]  = DEF_HP;
        end
        m_ack = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] en, input bit ld, input int sel, input int hpv);
        int  v;
        bit  hit;
        v     = (hpv == 0) ? 1 : hpv;
        m_ack = ld && (sel < CH);
        for (int c = 0; c < CH; c++) begin
            hit       = m_ack && (sel == c);
            m_tick[c] = 0;
            if (!m_run[c]) begin
                if (m_pend[c]) begin m_hp[c] = m_hpp[c]; m_pend[c] = 0; end
                if (hit) begin m_hp[c] = v; m_pend[c] = 0; end
                if (en[c]) begin
                    m_run[c] = 1;
                    m_lvl[c] = 0;
                    m_rem[c] = m_hp[c];
                end
            end else begin
                if (!en[c] && !m_lvl[c]) begin
                    m_run[c] = 0;
                    if (m_pend[c]) begin m_hp[c] = m_hpp[c]; m_pend[c] = 0; end
                end else begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_lvl[c]  = !m_lvl[c];
                        m_tick[c] = m_lvl[c];
                        if (m_pend[c]) begin m_hp[c] = m_hpp[c]; m_pend[c] = 0; end
                        if (!en[c] && !m_lvl[c]) m_run[c] = 0;
                        else m_rem[c] = m_hp[c];
                    end
                end
                if (hit) begin m_hpp[c] = v; m_pend[c] = 1; end
            end
        end
    endtask

    task automatic compare_outputs(input string where);
        logic [CH-1:0] e_clk, e_tick;
        for (int c = 0; c < CH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
        end
        check({where, ".clk_out"}, 32'(clk_out), 32'(e_clk));
        check({where, ".tick"}, 32'(tick), 32'(e_tick));
        check({where, ".load_ack"}, 32'(load_ack), 32'(m_ack));
    endtask

    task automatic step(input logic [CH-1:0] en, input bit ld, input logic [1:0] sel, input logic [CW-1:0] hpv);
        ch_en       = en;
        load        = ld;
        ch_sel      = sel;
        half_period = hpv;
        @(posedge clk_in);
        if (!reset) model_step(en, ld, int'(sel), int'(hpv));
        #1;
        compare_outputs("cyc");
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(en_v, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_outputs("async_rst");
        @(posedge clk_in);
        #1;
        compare_outputs("rst_hold");
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        model_reset();
        #1;
        compare_outputs("reset");
        @(posedge clk_in);
        #1;
        compare_outputs("reset_edge");
        @(negedge clk_in);
        reset = 1'b0;

        // Channel 0 at default half-period.
        en_v = 3'b001;
        run(30);

        // Reload ch0 to 3 partway through a high phase.
        for (k = 0; k < 40 && !(m_lvl[0] && m_rem[0] == 3); k++) run(1);
        check("wait_mid_high", 32'(m_lvl[0] && m_rem[0] == 3), 32'd1);
        step(en_v, 1'b1, 2'd0, 8'd3);
        run(20);

        // Load 0 into ch1 while stopped, then enable: clk_in/2.
        step(en_v, 1'b1, 2'd1, 8'd0);
        en_v = 3'b011;
        run(12);

        // Restore hp=5 on ch0, then disable one cycle after a rise (drain).
        step(en_v, 1'b1, 2'd0, 8'd5);
        run(14);
        for (k = 0; k < 40 && !m_tick[0]; k++) run(1);
        check("wait_rise", 32'(m_tick[0]), 32'd1);
        run(1);
        en_v = 3'b010;
        run(12);
        check("drain_done", 32'(clk_out[0]), 32'd0);

        // Disable during low phase: immediate stop.
        en_v = 3'b011;
        run(3);
        for (k = 0; k < 40 && !(m_run[0] && !m_lvl[0]); k++) run(1);
        check("wait_low", 32'(m_run[0] && !m_lvl[0]), 32'd1);
        en_v = 3'b010;
        run(8);

        // Out-of-range target is ignored.
        en_v = 3'b011;
        run(4);
        step(en_v, 1'b1, 2'd3, 8'd7);
        run(12);

        // Reset during a high phase, then confirm the default period returns.
        for (k = 0; k < 40 && !m_lvl[0]; k++) run(1);
        check("wait_high", 32'(m_lvl[0]), 32'd1);
        do_reset();
        en_v = 3'b001;
        run(25);

        // Widest legal half-period on ch2.
        step(en_v, 1'b1, 2'd2, 8'd255);
        en_v = 3'b101;
        run(600);

        // Randomized enables, loads and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 15) == 0) en_v[c] = ~en_v[c];
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step(en_v, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
